// File: rtl/compute_host_ctrl_pkg.sv
// Shared definitions for the compute host controller.
// Holds the default job geometry (also used by the sequencer side) and the
// controller state encoding.
package compute_host_ctrl_pkg;

    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefAddrW = 4;
    localparam int unsigned DefDepth = 16;

    // Encoding is fixed so that state values match the sequencer's view.
    typedef enum logic [1:0] {
        StLoad  = 2'd0,
        StStart = 2'd1,
        StWait  = 2'd2,
        StDrain = 2'd3
    } state_e;

endpackage

// File: rtl/compute_host_ctrl_if.sv
// Bus bundle for compute_host_ctrl.
// Groups the input word stream, input-BRAM write port, sequencer start and
// monitor signals, output-BRAM read port, result stream and status.
//   master : controller view (drives s_ready, BRAM ports, start, results, status)
//   slave  : environment view (drives input stream, sequencer monitor, read data,
//            m_ready)
interface compute_host_ctrl_if
    import compute_host_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              wr_en_in;
    logic [ADDR_W-1:0] wr_addr_in;
    logic [DATA_W-1:0] wr_data_in;
    logic              start;
    logic              seq_en_wr;
    logic [ADDR_W-1:0] seq_addr_wr;
    logic              rd_en_out;
    logic [ADDR_W-1:0] rd_addr_out;
    logic [DATA_W-1:0] rd_data_out;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              busy;
    logic              done;

    modport master (
        input  s_data, s_valid, seq_en_wr, seq_addr_wr, rd_data_out, m_ready,
        output s_ready, wr_en_in, wr_addr_in, wr_data_in, start,
               rd_en_out, rd_addr_out, m_data, m_valid, busy, done
    );

    modport slave (
        output s_data, s_valid, seq_en_wr, seq_addr_wr, rd_data_out, m_ready,
        input  s_ready, wr_en_in, wr_addr_in, wr_data_in, start,
               rd_en_out, rd_addr_out, m_data, m_valid, busy, done
    );
endinterface

// File: rtl/compute_host_ctrl_bram_read_slot.sv
// Single-entry read slot between output-BRAM port B and the result stream.
// Issues at most one read at a time, captures the read data one cycle later
// into a holding register, and presents it on a valid/ready handshake.
//   clk, rst     : clock, synchronous active-high reset
//   issue_ok_i   : controller permits a read (in DRAIN, words left to read)
//   rd_en_o      : read enable to the BRAM
//   rd_data_i    : BRAM read data, valid the cycle after rd_en_o
//   m_data_o/m_valid_o/m_ready_i : result stream
//   accept_o     : result handshake completed this cycle
module compute_host_ctrl_bram_read_slot #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_ok_i,
    output logic              rd_en_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              accept_o
);
    logic              inflight_q, inflight_d;
    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;

    always_comb begin
        // A read may be issued only if the holding register is free by the time
        // the data returns: empty now, or being accepted this cycle.
        rd_en_o    = issue_ok_i && !inflight_q && (!m_valid_q || m_ready_i);
        accept_o   = m_valid_q && m_ready_i && !rst;
        inflight_d = rd_en_o;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        if (inflight_q) begin
            m_valid_d = 1'b1;
            m_data_d  = rd_data_i;
        end else if (accept_o) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
        end else begin
            inflight_q <= inflight_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
        end
    end

    // Outputs forced low while reset is held, not just after the reset edge.
    assign m_valid_o = m_valid_q && !rst;
    assign m_data_o  = rst ? '0 : m_data_q;

endmodule

// File: rtl/compute_host_ctrl.sv
// Host-side controller for the BRAM->PE->BRAM compute sequencer.
// LOAD   : accept DEPTH words and write them to input-BRAM port B.
// START  : one-cycle start pulse to the sequencer.
// WAIT   : watch sequencer output-BRAM writes until the last address is written.
// DRAIN  : read output-BRAM port B and stream results; done on the last accept.
//   clk, rst : clock, synchronous active-high reset (all outputs 0 while high)
//   bus      : compute_host_ctrl_if master modport (streams, BRAM ports, status)
module compute_host_ctrl
    import compute_host_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DEPTH  = DefDepth
) (
    input  logic clk,
    input  logic rst,
    compute_host_ctrl_if.master bus
);
    // One spare bit so the DEPTH == 2**ADDR_W bound never wraps.
    localparam int unsigned CntW = ADDR_W + 1;
    localparam logic [CntW-1:0] LastIdx  = CntW'(DEPTH - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    state_e            state_q, state_d;
    logic [CntW-1:0]   ld_cnt_q, ld_cnt_d;
    logic [CntW-1:0]   rd_cnt_q, rd_cnt_d;
    logic [CntW-1:0]   out_cnt_q, out_cnt_d;

    logic              s_ready;
    logic              s_accept;
    logic              start;
    logic              done;
    logic              issue_ok;
    logic              rd_en;
    logic              m_accept;

    always_comb begin
        state_d   = state_q;
        ld_cnt_d  = ld_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        out_cnt_d = out_cnt_q;
        s_ready   = 1'b0;
        s_accept  = 1'b0;
        start     = 1'b0;
        done      = 1'b0;
        issue_ok  = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StLoad: begin
                    s_ready  = 1'b1;
                    s_accept = bus.s_valid;
                    if (s_accept) begin
                        ld_cnt_d = ld_cnt_q + 1'b1;
                        if (ld_cnt_q == LastIdx) state_d = StStart;
                    end
                end
                StStart: begin
                    start   = 1'b1;
                    state_d = StWait;
                end
                StWait: begin
                    if (bus.seq_en_wr && ({1'b0, bus.seq_addr_wr} == LastIdx)) begin
                        state_d = StDrain;
                    end
                end
                StDrain: begin
                    issue_ok = (rd_cnt_q < DepthCnt);
                    if (rd_en) rd_cnt_d = rd_cnt_q + 1'b1;
                    if (m_accept) begin
                        out_cnt_d = out_cnt_q + 1'b1;
                        if (out_cnt_q == LastIdx) begin
                            done      = 1'b1;
                            state_d   = StLoad;
                            ld_cnt_d  = '0;
                            rd_cnt_d  = '0;
                            out_cnt_d = '0;
                        end
                    end
                end
                default: state_d = StLoad;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StLoad;
            ld_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ld_cnt_q  <= ld_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    compute_host_ctrl_bram_read_slot #(
        .DATA_W (DATA_W)
    ) u_read_slot (
        .clk        (clk),
        .rst        (rst),
        .issue_ok_i (issue_ok),
        .rd_en_o    (rd_en),
        .rd_data_i  (bus.rd_data_out),
        .m_data_o   (bus.m_data),
        .m_valid_o  (bus.m_valid),
        .m_ready_i  (bus.m_ready),
        .accept_o   (m_accept)
    );

    assign bus.s_ready     = s_ready;
    assign bus.wr_en_in    = s_accept;
    assign bus.wr_addr_in  = rst ? '0 : ld_cnt_q[ADDR_W-1:0];
    assign bus.wr_data_in  = s_accept ? bus.s_data : '0;
    assign bus.start       = start;
    assign bus.rd_en_out   = rd_en;
    assign bus.rd_addr_out = rst ? '0 : rd_cnt_q[ADDR_W-1:0];
    assign bus.busy        = !rst && (state_q != StLoad);
    assign bus.done        = done;

endmodule

// File: tb/tb_compute_host_ctrl.sv
module tb_compute_host_ctrl;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned DP = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    compute_host_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    compute_host_ctrl #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Output-BRAM model: word at address a holds a + 0x80, one-cycle latency.
    always @(posedge clk) begin
        if (bus.rd_en_out) bus.rd_data_out <= 8'h80 + {4'h0, bus.rd_addr_out};
    end

    function automatic logic [10:0] outs();
        return {bus.s_ready, bus.wr_en_in, bus.start, bus.rd_en_out, bus.m_valid,
                bus.busy, bus.done, |bus.wr_addr_in, |bus.wr_data_in,
                |bus.rd_addr_out, |bus.m_data};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.s_valid = 1'b1; bus.s_data = 8'hA5;
        bus.seq_en_wr = 1'b1; bus.seq_addr_wr = 4'hF; bus.m_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            vectors++;
            if (outs() !== 11'd0) begin
                miscompares++;
                $display("FAIL reset_outputs cycle %0d: got %b expected 0", i, outs());
            end
        end
        @(negedge clk);
        rst = 1'b0;
        bus.s_valid = 1'b0; bus.seq_en_wr = 1'b0; bus.seq_addr_wr = '0;
        #1;
        vectors++;
        if ({bus.s_ready, bus.busy, bus.start, bus.m_valid} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_release: got s_ready/busy/start/m_valid=%b expected 1000",
                     {bus.s_ready, bus.busy, bus.start, bus.m_valid});
        end
    endtask

    // Loads 16 words base..base+15; ends on the START-cycle check.
    task automatic test_load(input logic [7:0] base, input bit stray);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_data = base + 8'(i);
            bus.seq_en_wr = stray && (i == 8);
            bus.seq_addr_wr = 4'hF;
            #1;
            vectors++;
            if ({bus.wr_en_in, bus.wr_addr_in, bus.wr_data_in, bus.start, bus.busy} !==
                {1'b1, 4'(i), base + 8'(i), 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL load_write %0d: got en=%b addr=%h data=%h start=%b busy=%b expected en=1 addr=%h data=%h start=0 busy=0",
                         i, bus.wr_en_in, bus.wr_addr_in, bus.wr_data_in, bus.start, bus.busy,
                         4'(i), base + 8'(i));
            end
        end
        @(negedge clk);
        bus.seq_en_wr = 1'b0;
        #1;
        vectors++;
        if ({bus.start, bus.s_ready, bus.wr_en_in, bus.busy} !== 4'b1001) begin
            miscompares++;
            $display("FAIL start_pulse: got start/s_ready/wr_en/busy=%b expected 1001",
                     {bus.start, bus.s_ready, bus.wr_en_in, bus.busy});
        end
    endtask

    // Sequencer writes addr 0..15; DRAIN must not begin before the addr-15 write.
    task automatic test_wait();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.s_valid = (i < 2);
            bus.seq_en_wr = 1'b1;
            bus.seq_addr_wr = 4'(i);
            #1;
            vectors++;
            if ({bus.rd_en_out, bus.start, bus.s_ready, bus.wr_en_in, bus.busy} !== 5'b00001) begin
                miscompares++;
                $display("FAIL wait_hold %0d: got rd_en/start/s_ready/wr_en/busy=%b expected 00001",
                         i, {bus.rd_en_out, bus.start, bus.s_ready, bus.wr_en_in, bus.busy});
            end
        end
    endtask

    // Drains 16 results; stall_idx >= 0 holds m_ready low 5 cycles at that result.
    task automatic test_drain(input int stall_idx);
        int k = 0;
        int cyc = 0;
        int last = -1;
        int rdk = 0;
        int stall_left = (stall_idx >= 0) ? 5 : 0;
        while (k < 16 && cyc < 200) begin
            @(negedge clk);
            bus.seq_en_wr = 1'b0;
            bus.s_valid = 1'b0;
            if (stall_left > 0 && bus.m_valid && k == stall_idx) begin
                bus.m_ready = 1'b0;
                #1;
                vectors++;
                if ({bus.m_valid, bus.m_data, bus.rd_en_out, bus.done} !==
                    {1'b1, 8'h80 + 8'(k), 1'b0, 1'b0}) begin
                    miscompares++;
                    $display("FAIL stall_hold %0d: got valid=%b data=%h rd_en=%b done=%b expected valid=1 data=%h rd_en=0 done=0",
                             stall_left, bus.m_valid, bus.m_data, bus.rd_en_out, bus.done,
                             8'h80 + 8'(k));
                end
                stall_left--;
            end else begin
                bus.m_ready = 1'b1;
                #1;
                if (bus.rd_en_out) begin
                    vectors++;
                    if (bus.rd_addr_out !== 4'(rdk)) begin
                        miscompares++;
                        $display("FAIL read_addr: got %h expected %h", bus.rd_addr_out, 4'(rdk));
                    end
                    rdk++;
                end
                if (bus.m_valid) begin
                    vectors++;
                    if ({bus.m_data, bus.done} !== {8'h80 + 8'(k), k == 15}) begin
                        miscompares++;
                        $display("FAIL result %0d: got data=%h done=%b expected data=%h done=%b",
                                 k, bus.m_data, bus.done, 8'h80 + 8'(k), k == 15);
                    end
                    if (stall_idx < 0 && last >= 0) begin
                        vectors++;
                        if (cyc - last != 2) begin
                            miscompares++;
                            $display("FAIL beat_spacing %0d: got %0d cycles expected 2",
                                     k, cyc - last);
                        end
                    end
                    last = cyc;
                    k++;
                end else if (bus.done) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_done: got 1 expected 0 at cycle %0d", cyc);
                end
            end
            cyc++;
        end
        vectors++;
        if (k != 16 || rdk != 16) begin
            miscompares++;
            $display("FAIL drain_count: got results=%0d reads=%0d expected 16 16", k, rdk);
        end
        @(negedge clk); #1;
        vectors++;
        if ({bus.s_ready, bus.busy, bus.m_valid, bus.rd_en_out} !== 4'b1000) begin
            miscompares++;
            $display("FAIL after_done: got s_ready/busy/m_valid/rd_en=%b expected 1000",
                     {bus.s_ready, bus.busy, bus.m_valid, bus.rd_en_out});
        end
    endtask

    task automatic test_reset_in_wait();
        test_load(8'h20, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.s_valid = 1'b0;
            bus.seq_en_wr = 1'b1;
            bus.seq_addr_wr = 4'(i);
        end
        @(negedge clk);
        bus.seq_en_wr = 1'b0;
        rst = 1'b1;
        #1;
        vectors++;
        if (outs() !== 11'd0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got %b expected 0", outs());
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if ({bus.s_ready, bus.busy, bus.start, bus.rd_en_out} !== 4'b1000) begin
                miscompares++;
                $display("FAIL midrst_idle %0d: got s_ready/busy/start/rd_en=%b expected 1000",
                         i, {bus.s_ready, bus.busy, bus.start, bus.rd_en_out});
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bus.s_valid = 1'b0; bus.s_data = '0; bus.seq_en_wr = 1'b0;
        bus.seq_addr_wr = '0; bus.m_ready = 1'b0;
        test_reset();
        test_load(8'h10, 1'b1);
        test_wait();
        test_drain(-1);
        test_load(8'h40, 1'b0);
        test_wait();
        test_drain(5);
        test_reset_in_wait();
        test_load(8'h30, 1'b0);
        test_wait();
        test_drain(-1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
